// File: rtl/fp_sign_unit.sv
// fp_sign_unit: multi-lane floating-point sign manipulation with a 2-entry
// output buffer.
//
// Each lane of in_data (operand A) keeps its magnitude bits and gets a new
// sign bit chosen by in_mode: pass, negate, abs, negative-abs, copysign from
// in_sgn (operand B), or xor with B's sign. Lanes with in_mask[i]=0 pass A
// unchanged. NaN/Inf/zero are not special-cased.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   in_valid / in_ready      input handshake; in_ready depends only on
//                            registered occupancy (and rst)
//   in_data, in_sgn          operand vectors, lane i at [i*DATA_W +: DATA_W]
//   in_mode, in_mask         operation select and per-lane enable
//   out_valid / out_ready    output handshake
//   out_data                 head entry of the buffer
//   done_cnt                 wrapping count of beats popped from the output
//   illegal_mode             sticky; set when a beat with in_mode > 5 is accepted
module fp_sign_unit #(
   parameter int DATA_W = 16,
   parameter int LANES  = 4,
   parameter int CNT_W  = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [LANES*DATA_W-1:0] in_data,
   input  logic [LANES*DATA_W-1:0] in_sgn,
   input  logic [2:0]              in_mode,
   input  logic [LANES-1:0]        in_mask,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [LANES*DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]        done_cnt,
   output logic                    illegal_mode
);

   localparam int VEC_W = LANES * DATA_W;

   localparam logic [2:0] MODE_PASS = 3'd0;
   localparam logic [2:0] MODE_NEG  = 3'd1;
   localparam logic [2:0] MODE_ABS  = 3'd2;
   localparam logic [2:0] MODE_NABS = 3'd3;
   localparam logic [2:0] MODE_CPY  = 3'd4;
   localparam logic [2:0] MODE_XOR  = 3'd5;

   logic [VEC_W-1:0] mem [2];
   logic             rd_ptr;
   logic             wr_ptr;
   logic [1:0]       occ;
   logic [VEC_W-1:0] result;
   logic             push;
   logic             pop;

   function automatic logic new_sign(input logic [2:0] mode, input logic s, input logic b);
      logic r;
      case (mode)
         MODE_PASS: r = s;
         MODE_NEG:  r = ~s;
         MODE_ABS:  r = 1'b0;
         MODE_NABS: r = 1'b1;
         MODE_CPY:  r = b;
         MODE_XOR:  r = s ^ b;
         default:   r = s;   // undefined modes behave as pass
      endcase
      return r;
   endfunction

   // Only the top bit of each lane is rewritten; magnitude bits flow through.
   always_comb begin
      result = in_data;
      for (int i = 0; i < LANES; i++) begin
         if (in_mask[i]) begin
            result[i*DATA_W + DATA_W - 1] = new_sign(in_mode,
                                                     in_data[i*DATA_W + DATA_W - 1],
                                                     in_sgn[i*DATA_W + DATA_W - 1]);
         end
      end
   end

   // Gated by rst so the unit never advertises space during the reset cycle.
   assign in_ready  = !rst && (occ != 2'd2);
   assign out_valid = (occ != 2'd0);
   assign out_data  = mem[rd_ptr];

   assign push = in_valid && in_ready;
   assign pop  = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         occ          <= 2'd0;
         rd_ptr       <= 1'b0;
         wr_ptr       <= 1'b0;
         mem[0]       <= '0;
         mem[1]       <= '0;
         done_cnt     <= '0;
         illegal_mode <= 1'b0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= result;
            wr_ptr      <= ~wr_ptr;
            if (in_mode > MODE_XOR) begin
               illegal_mode <= 1'b1;
            end
         end
         if (pop) begin
            rd_ptr   <= ~rd_ptr;
            done_cnt <= done_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
         end
         // Push and pop together leave occupancy unchanged; at occupancy 1
         // the head pointer moves onto the entry written this edge.
         case ({push, pop})
            2'b10:   occ <= occ + 2'd1;
            2'b01:   occ <= occ - 2'd1;
            default: occ <= occ;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_sign_unit.sv
module tb_fp_sign_unit;

   localparam int DATA_W = 16;
   localparam int LANES  = 4;
   localparam int CNT_W  = 16;
   localparam int VEC_W  = DATA_W * LANES;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [VEC_W-1:0] in_data;
   logic [VEC_W-1:0] in_sgn;
   logic [2:0]       in_mode;
   logic [LANES-1:0] in_mask;
   logic             out_valid;
   logic             out_ready;
   logic [VEC_W-1:0] out_data;
   logic [CNT_W-1:0] done_cnt;
   logic             illegal_mode;

   int               n_cmp = 0;
   int               n_err = 0;
   logic [VEC_W-1:0] exp_q[$];
   int               pops_model = 0;
   bit               ill_model = 0;
   bit               last_push;

   fp_sign_unit #(.DATA_W(DATA_W), .LANES(LANES), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_sgn(in_sgn), .in_mode(in_mode), .in_mask(in_mask),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .done_cnt(done_cnt), .illegal_mode(illegal_mode)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [VEC_W-1:0] obs, input logic [VEC_W-1:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Reference: rebuild each lane as magnitude plus a chosen sign weight.
   function automatic logic [VEC_W-1:0] ref_vec(input logic [VEC_W-1:0] a_v, input logic [VEC_W-1:0] b_v,
                                               input int mode, input logic [LANES-1:0] mask);
      logic [VEC_W-1:0] r;
      for (int i = 0; i < LANES; i++) begin
         int a, b, mag;
         bit sa, sb, neg;
         a   = int'(a_v[i*DATA_W +: DATA_W]);
         b   = int'(b_v[i*DATA_W +: DATA_W]);
         mag = a % 32768;
         sa  = (a >= 32768);
         sb  = (b >= 32768);
         if (!mask[i])        neg = sa;
         else if (mode == 1)  neg = !sa;
         else if (mode == 2)  neg = 0;
         else if (mode == 3)  neg = 1;
         else if (mode == 4)  neg = sb;
         else if (mode == 5)  neg = (sa != sb);
         else                 neg = sa;
         r[i*DATA_W +: DATA_W] = DATA_W'(mag + (neg ? 32768 : 0));
      end
      return r;
   endfunction

   // One clock of traffic: check handshakes against the model, update the
   // scoreboard with whatever transfers at this edge, then check registered state.
   task automatic cycle();
      bit push, pop;
      chk("in_ready", {63'd0, in_ready}, {63'd0, exp_q.size() != 2});
      chk("out_valid", {63'd0, out_valid}, {63'd0, exp_q.size() != 0});
      push = in_valid && in_ready;
      pop  = out_valid && out_ready;
      if (pop && exp_q.size() > 0) begin
         chk("pop_data", out_data, exp_q[0]);
         void'(exp_q.pop_front());
         pops_model++;
      end
      if (push) begin
         exp_q.push_back(ref_vec(in_data, in_sgn, int'(in_mode), in_mask));
         if (in_mode > 5) ill_model = 1;
      end
      last_push = push;
      @(posedge clk);
      #1;
      chk("done_cnt", {48'd0, done_cnt}, {48'd0, 16'(pops_model % 65536)});
      chk("illegal_mode", {63'd0, illegal_mode}, {63'd0, ill_model});
   endtask

   task automatic directed(input string tag, input int mode, input logic [3:0] mask,
                           input logic [VEC_W-1:0] a, input logic [VEC_W-1:0] b,
                           input logic [VEC_W-1:0] expv);
      in_mode  = 3'(mode);
      in_mask  = mask;
      in_data  = a;
      in_sgn   = b;
      in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      chk({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
      chk(tag, out_data, expv);
      cycle();
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      in_data = '0; in_sgn = '0; in_mode = '0; in_mask = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_out_data", out_data, 64'd0);
      chk("rst_done_cnt", {48'd0, done_cnt}, 64'd0);
      chk("rst_illegal", {63'd0, illegal_mode}, 64'd0);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

      out_ready = 1'b1;
      directed("neg", 1, 4'hF, {16'h7E00, 16'h0000, 16'hBC00, 16'h3C00}, '0,
               {16'hFE00, 16'h8000, 16'h3C00, 16'hBC00});
      chk("neg_done_cnt", {48'd0, done_cnt}, 64'd1);
      directed("abs", 2, 4'hF, {16'hFC00, 16'h8000, 16'h4000, 16'hC000}, '0,
               {16'h7C00, 16'h0000, 16'h4000, 16'h4000});
      directed("nabs", 3, 4'hF, {16'hFC00, 16'h8000, 16'h4000, 16'hC000}, '0,
               {16'hFC00, 16'h8000, 16'hC000, 16'hC000});
      directed("copysign", 4, 4'hF, {4{16'h3C00}}, {16'h7FFF, 16'hFFFF, 16'h0000, 16'h8000},
               {16'h3C00, 16'hBC00, 16'h3C00, 16'hBC00});
      directed("xorsign", 5, 4'hF, {4{16'h3C00}}, {16'h7FFF, 16'hFFFF, 16'h0000, 16'h8000},
               {16'h3C00, 16'hBC00, 16'h3C00, 16'hBC00});
      directed("mask", 1, 4'b0101, {4{16'h3C00}}, '0,
               {16'h3C00, 16'hBC00, 16'h3C00, 16'hBC00});

      // Backpressure: V0, V1 fill the buffer, V2 is held upstream.
      out_ready = 1'b0;
      in_mode = 3'd1; in_mask = 4'hF; in_sgn = '0;
      in_valid = 1'b1;
      in_data = 64'h1111_2222_3333_4444; cycle();
      in_data = 64'h5555_6666_7777_8888; cycle();
      in_data = 64'h9999_AAAA_BBBB_CCCC;
      for (int k = 0; k < 3; k++) begin
         chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
         chk("stall_hold", out_data, 64'h9111_A222_B333_C444);
         cycle();
      end
      out_ready = 1'b1;
      for (int k = 0; k < 10 && !last_push; k++) cycle();
      chk("v2_accepted", {63'd0, last_push}, 64'd1);
      in_valid = 1'b0;
      for (int k = 0; k < 10 && exp_q.size() > 0; k++) cycle();
      chk("drain_empty", 64'(exp_q.size()), 64'd0);

      directed("mode7", 7, 4'hF, 64'hBC00_7E00_FC00_3C00, 64'hFFFF_FFFF_FFFF_FFFF,
               64'hBC00_7E00_FC00_3C00);
      directed("after_mode7", 0, 4'hF, 64'h0123_4567_89AB_CDEF, '0,
               64'h0123_4567_89AB_CDEF);

      // Random traffic; an unaccepted beat is held until it is taken.
      last_push = 1'b1;
      for (int k = 0; k < 400; k++) begin
         if (!in_valid || last_push) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = {$urandom, $urandom};
            in_sgn   = {$urandom, $urandom};
            in_mode  = 3'($urandom_range(0, 7));
            in_mask  = 4'($urandom_range(0, 15));
         end
         out_ready = ($urandom_range(0, 2) != 0);
         cycle();
      end
      in_valid = 1'b0;

      // Reset with two beats buffered.
      out_ready = 1'b0;
      if (exp_q.size() > 0) begin
         out_ready = 1'b1;
         for (int k = 0; k < 10 && exp_q.size() > 0; k++) cycle();
         out_ready = 1'b0;
      end
      in_valid = 1'b1; in_mode = 3'd6; in_mask = 4'hF;
      in_data = 64'hAAAA_0000_5555_FFFF; cycle();
      in_data = 64'h0F0F_F0F0_1234_8765; cycle();
      in_valid = 1'b0;
      chk("pre_rst_full", {63'd0, out_valid}, 64'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("midrst_done_cnt", {48'd0, done_cnt}, 64'd0);
      chk("midrst_illegal", {63'd0, illegal_mode}, 64'd0);
      chk("midrst_in_ready", {63'd0, in_ready}, 64'd0);
      exp_q.delete();
      pops_model = 0;
      ill_model = 0;
      rst = 1'b0;
      #1;

      // Counter wrap: 65535 pops to reach 0xFFFF, then one more.
      out_ready = 1'b1; in_valid = 1'b1; in_mode = 3'd0; in_mask = 4'hF;
      in_data = 64'h0000_1111_2222_3333;
      for (int k = 0; k < 70000 && pops_model < 65535; k++) cycle();
      chk("cnt_ffff", {48'd0, done_cnt}, 64'h0000_0000_0000_FFFF);
      for (int k = 0; k < 10 && pops_model < 65536; k++) cycle();
      chk("cnt_wrap", {48'd0, done_cnt}, 64'd0);
      in_valid = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
